// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the calculator datapath and the seven-segment scan driver.
// The datapath is the master; the scan driver is the slave.
interface seg7_scan_driver_if;
  logic        en;
  logic [20:0] disp_num;
  logic [20:0] disp_result;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        frame_tick;

  modport master (
    output en, disp_num, disp_result,
    input  seg, an, frame_tick
  );

  modport slave (
    input  en, disp_num, disp_result,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes six seven-segment digits (3 operand + 3 result) onto one segment bus.
// Each slot starts with a blanking interval, and the digit codes are captured only at frame wrap.
module seg7_scan_driver #(
  parameter int         CNT_DIV       = 50000,
  parameter int         DEAD          = 16,
  parameter logic [6:0] SEG_OFF       = 7'h7F,
  parameter bit         AN_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int               DIV_W    = $clog2(CNT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);
  localparam logic [5:0]       AN_OFF   = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  if (CNT_DIV < 2) begin : g_badCntDiv
    $error("seg7_scan_driver: CNT_DIV must be at least 2");
  end
  if (DEAD < 0 || DEAD >= CNT_DIV) begin : g_badDead
    $error("seg7_scan_driver: DEAD must satisfy 0 <= DEAD < CNT_DIV");
  end

  // ST_LOAD waits for the first enabled cycle to fill the shadow registers.
  typedef enum logic {
    ST_LOAD,
    ST_SCAN
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_capture;

  logic [DIV_W-1:0] r_divCnt;
  logic [2:0]       r_idx;
  logic [6:0]       r_shadow [6];

  logic [6:0]       r_seg;
  logic [5:0]       r_an;
  logic             r_frameTick;

  logic             w_lastCnt;
  logic             w_lastIdx;
  logic             w_wrap;
  logic             w_inDead;
  logic [6:0]       w_liveDigit;
  logic [6:0]       w_shadowDigit;
  logic [6:0]       w_digit;
  logic [5:0]       w_anOneHot;
  logic [5:0]       w_anActive;

  assign w_lastCnt = (r_divCnt == DIV_LAST);
  assign w_lastIdx = (r_idx == 3'd5);
  assign w_wrap    = bus.en && w_lastCnt && w_lastIdx;
  assign w_inDead  = int'(r_divCnt) < DEAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    if (bus.en) begin
      case (r_state)
        ST_LOAD: begin
          w_capture   = 1'b1;
          w_nextState = ST_SCAN;
        end
        ST_SCAN: begin
          w_capture = w_wrap;
        end
        default: begin
          w_nextState = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_divCnt <= '0;
      r_idx    <= 3'd0;
    end else if (bus.en) begin
      if (w_lastCnt) begin
        r_divCnt <= '0;
        r_idx    <= w_lastIdx ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_divCnt <= r_divCnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        r_shadow[i] <= SEG_OFF;
      end
    end else if (w_capture) begin
      r_shadow[0] <= bus.disp_num[6:0];
      r_shadow[1] <= bus.disp_num[13:7];
      r_shadow[2] <= bus.disp_num[20:14];
      r_shadow[3] <= bus.disp_result[6:0];
      r_shadow[4] <= bus.disp_result[13:7];
      r_shadow[5] <= bus.disp_result[20:14];
    end
  end

  // While the initial load is pending the shadow is still blank, so the live input
  // is shown instead; otherwise a zero-dead-time setup would blank digit 0 once.
  always_comb begin
    w_liveDigit   = SEG_OFF;
    w_shadowDigit = SEG_OFF;
    case (r_idx)
      3'd0: begin
        w_liveDigit   = bus.disp_num[6:0];
        w_shadowDigit = r_shadow[0];
      end
      3'd1: begin
        w_liveDigit   = bus.disp_num[13:7];
        w_shadowDigit = r_shadow[1];
      end
      3'd2: begin
        w_liveDigit   = bus.disp_num[20:14];
        w_shadowDigit = r_shadow[2];
      end
      3'd3: begin
        w_liveDigit   = bus.disp_result[6:0];
        w_shadowDigit = r_shadow[3];
      end
      3'd4: begin
        w_liveDigit   = bus.disp_result[13:7];
        w_shadowDigit = r_shadow[4];
      end
      3'd5: begin
        w_liveDigit   = bus.disp_result[20:14];
        w_shadowDigit = r_shadow[5];
      end
      default: begin
        w_liveDigit   = SEG_OFF;
        w_shadowDigit = SEG_OFF;
      end
    endcase
    w_digit = (r_state == ST_LOAD) ? w_liveDigit : w_shadowDigit;
  end

  assign w_anOneHot = 6'b000001 << r_idx;
  assign w_anActive = AN_ACTIVE_LOW ? ~w_anOneHot : w_anOneHot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= w_wrap;
      if (bus.en && !w_inDead) begin
        r_seg <= w_digit;
        r_an  <= w_anActive;
      end else begin
        r_seg <= SEG_OFF;
        r_an  <= AN_OFF;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frameTick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: an 8-cycle slot with 2 blank cycles (dutA)
// and a zero-dead-time instance (dutB).
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstNd = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [6:0] codes [6];
  logic [6:0] codesB [6];

  seg7_scan_driver_if busA ();
  seg7_scan_driver_if busB ();

  seg7_scan_driver #(
    .CNT_DIV(8), .DEAD(2), .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b1)
  ) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );

  seg7_scan_driver #(
    .CNT_DIV(8), .DEAD(0), .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b1)
  ) dutB (
    .clk(clk), .rst(rstNd), .bus(busB)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] anFor(input int slot);
    logic [5:0] v;
    v = 6'b000001 << slot;
    return ~v;
  endfunction

  task automatic applyStimulus(input logic enA);
    busA.en = enA;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    busA.disp_num    = {7'h30, 7'h6D, 7'h79};
    busA.disp_result = {7'h33, 7'h5B, 7'h06};
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1);
      total++;
      if (busA.an !== 6'h3F) begin
        bad++;
        $display("[TB] FAIL reset_an c=%0d got=%h exp=3f", c, busA.an);
      end
      total++;
      if (busA.seg !== 7'h7F) begin
        bad++;
        $display("[TB] FAIL reset_seg c=%0d got=%h exp=7f", c, busA.seg);
      end
      total++;
      if (busA.frame_tick !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_tick c=%0d got=%b exp=0", c, busA.frame_tick);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_order;
    int ticks;
    int pos;
    int slot;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expFt;
    ticks = 0;
    for (int k = 1; k <= 96; k++) begin
      applyStimulus(1'b1);
      pos    = (k - 1) % 8;
      slot   = ((k - 1) / 8) % 6;
      expAn  = (pos < 2) ? 6'h3F : anFor(slot);
      expSeg = (pos < 2) ? 7'h7F : codes[slot];
      expFt  = (k % 48 == 0);
      if (busA.frame_tick === 1'b1) ticks++;
      total++;
      if (busA.an !== expAn) begin
        bad++;
        $display("[TB] FAIL scan_an k=%0d got=%h exp=%h", k, busA.an, expAn);
      end
      total++;
      if (busA.seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL scan_seg k=%0d got=%h exp=%h", k, busA.seg, expSeg);
      end
      total++;
      if (busA.frame_tick !== expFt) begin
        bad++;
        $display("[TB] FAIL scan_tick k=%0d got=%b exp=%b", k, busA.frame_tick, expFt);
      end
    end
    total++;
    if (ticks != 2) begin
      bad++;
      $display("[TB] FAIL scan_tick_count got=%0d exp=2", ticks);
    end
  endtask

  task automatic test_double_buffer;
    int pos;
    int slot;
    int frame;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    for (int k = 1; k <= 96; k++) begin
      if (k == 10) busA.disp_result = {7'h3F, 7'h3F, 7'h3F};
      applyStimulus(1'b1);
      pos    = (k - 1) % 8;
      slot   = ((k - 1) / 8) % 6;
      frame  = (k - 1) / 48;
      expAn  = (pos < 2) ? 6'h3F : anFor(slot);
      expSeg = (pos < 2) ? 7'h7F : ((slot >= 3 && frame == 1) ? 7'h3F : codes[slot]);
      total++;
      if (busA.an !== expAn) begin
        bad++;
        $display("[TB] FAIL dbuf_an k=%0d got=%h exp=%h", k, busA.an, expAn);
      end
      total++;
      if (busA.seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL dbuf_seg k=%0d got=%h exp=%h", k, busA.seg, expSeg);
      end
    end
    codes[3] = 7'h3F;
    codes[4] = 7'h3F;
    codes[5] = 7'h3F;
  endtask

  task automatic test_enable_gating;
    int pos;
    int slot;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expFt;
    logic [20:0] savedNum;
    savedNum = busA.disp_num;
    for (int k = 1; k <= 48; k++) begin
      if (k == 31) begin
        for (int d = 0; d < 10; d++) begin
          busA.disp_num = 21'h1ABCDE;
          applyStimulus(1'b0);
          total++;
          if (busA.an !== 6'h3F) begin
            bad++;
            $display("[TB] FAIL gate_an d=%0d got=%h exp=3f", d, busA.an);
          end
          total++;
          if (busA.seg !== 7'h7F) begin
            bad++;
            $display("[TB] FAIL gate_seg d=%0d got=%h exp=7f", d, busA.seg);
          end
          total++;
          if (busA.frame_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gate_tick d=%0d got=%b exp=0", d, busA.frame_tick);
          end
        end
        busA.disp_num = savedNum;
      end
      applyStimulus(1'b1);
      pos    = (k - 1) % 8;
      slot   = (k - 1) / 8;
      expAn  = (pos < 2) ? 6'h3F : anFor(slot);
      expSeg = (pos < 2) ? 7'h7F : codes[slot];
      expFt  = (k == 48);
      total++;
      if (busA.an !== expAn) begin
        bad++;
        $display("[TB] FAIL gate_resume_an k=%0d got=%h exp=%h", k, busA.an, expAn);
      end
      total++;
      if (busA.seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL gate_resume_seg k=%0d got=%h exp=%h", k, busA.seg, expSeg);
      end
      total++;
      if (busA.frame_tick !== expFt) begin
        bad++;
        $display("[TB] FAIL gate_resume_tick k=%0d got=%b exp=%b", k, busA.frame_tick, expFt);
      end
    end
  endtask

  task automatic test_mid_reset;
    int pos;
    int slot;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expFt;
    for (int k = 1; k <= 33; k++) begin
      applyStimulus(1'b1);
    end
    busA.disp_num    = {7'h07, 7'h7F, 7'h6F};
    busA.disp_result = {7'h66, 7'h4F, 7'h5B};
    codes[0] = 7'h6F;
    codes[1] = 7'h7F;
    codes[2] = 7'h07;
    codes[3] = 7'h5B;
    codes[4] = 7'h4F;
    codes[5] = 7'h66;
    rst = 1'b1;
    applyStimulus(1'b1);
    rst = 1'b0;
    total++;
    if (busA.an !== 6'h3F || busA.seg !== 7'h7F || busA.frame_tick !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_values an=%h seg=%h tick=%b exp an=3f seg=7f tick=0",
               busA.an, busA.seg, busA.frame_tick);
    end
    for (int k = 1; k <= 48; k++) begin
      applyStimulus(1'b1);
      pos    = (k - 1) % 8;
      slot   = (k - 1) / 8;
      expAn  = (pos < 2) ? 6'h3F : anFor(slot);
      expSeg = (pos < 2) ? 7'h7F : codes[slot];
      expFt  = (k == 48);
      total++;
      if (busA.an !== expAn) begin
        bad++;
        $display("[TB] FAIL midrst_an k=%0d got=%h exp=%h", k, busA.an, expAn);
      end
      total++;
      if (busA.seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL midrst_seg k=%0d got=%h exp=%h", k, busA.seg, expSeg);
      end
      total++;
      if (busA.frame_tick !== expFt) begin
        bad++;
        $display("[TB] FAIL midrst_tick k=%0d got=%b exp=%b", k, busA.frame_tick, expFt);
      end
    end
  endtask

  task automatic test_no_dead;
    int slot;
    logic [5:0] expAn;
    logic [6:0] expSeg;
    logic       expFt;
    total++;
    if (busB.an !== 6'h3F || busB.seg !== 7'h7F) begin
      bad++;
      $display("[TB] FAIL nodead_reset an=%h seg=%h exp an=3f seg=7f", busB.an, busB.seg);
    end
    rstNd = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      applyStimulus(busA.en);
      slot   = ((k - 1) / 8) % 6;
      expAn  = anFor(slot);
      expSeg = codesB[slot];
      expFt  = (k == 48);
      total++;
      if (busB.an !== expAn) begin
        bad++;
        $display("[TB] FAIL nodead_an k=%0d got=%h exp=%h", k, busB.an, expAn);
      end
      total++;
      if (busB.seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL nodead_seg k=%0d got=%h exp=%h", k, busB.seg, expSeg);
      end
      total++;
      if (busB.frame_tick !== expFt) begin
        bad++;
        $display("[TB] FAIL nodead_tick k=%0d got=%b exp=%b", k, busB.frame_tick, expFt);
      end
    end
  endtask

  initial begin
    codes[0] = 7'h79;
    codes[1] = 7'h6D;
    codes[2] = 7'h30;
    codes[3] = 7'h06;
    codes[4] = 7'h5B;
    codes[5] = 7'h33;
    for (int i = 0; i < 6; i++) codesB[i] = codes[i];
    busA.en          = 1'b1;
    busA.disp_num    = {7'h30, 7'h6D, 7'h79};
    busA.disp_result = {7'h33, 7'h5B, 7'h06};
    busB.en          = 1'b1;
    busB.disp_num    = {7'h30, 7'h6D, 7'h79};
    busB.disp_result = {7'h33, 7'h5B, 7'h06};

    test_reset();
    test_scan_order();
    test_double_buffer();
    test_enable_gating();
    test_mid_reset();
    test_no_dead();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
